// File: rtl/spi_register_bridge_pkg.sv
// Shared definitions for the SPI register bridge: FSM states and the
// status-field bit indices in the response word.
package spi_register_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } bridge_state_t;

  localparam int STATUS_TIMEOUT = 0;
  localparam int STATUS_OVERRUN = 1;
  localparam int STATUS_INVALID = 2;
  localparam int STATUS_WRITE   = 3;
  localparam int STATUS_BITS    = 4;

endpackage

// File: rtl/spi_register_bridge_bus_timeout_counter.sv
// Counts cycles while a bus access is outstanding and flags expiry after
// TIMEOUT_CYCLES cycles; TIMEOUT_CYCLES = 0 never expires.
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic system_clk,
  input  logic system_nrst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CW-1:0] r_count;
  logic          w_expire;

  assign w_expire = (TIMEOUT_CYCLES != 0) && (r_count == CW'(TIMEOUT_CYCLES - 1));
  assign o_expire = w_expire;

  // Saturating count; holds once expired so it never wraps.
  always_ff @(posedge system_clk or negedge system_nrst) begin
    if (!system_nrst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !w_expire) begin
      r_count <= r_count + CW'(1);
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/spi_register_bridge.sv
// Decodes SPI words into register-bus read/write commands and returns the
// result (with status) as the transmit word for the following SPI frame.
module spi_register_bridge
  import spi_register_bridge_pkg::*;
#(
  parameter  int ADDR_WIDTH     = 7,
  parameter  int DATA_WIDTH     = 24,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int WIDTH          = 1 + ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                  system_clk,
  input  logic                  system_nrst,
  input  logic [WIDTH-1:0]      spi_value_mosi,
  input  logic                  spi_value_valid,
  input  logic                  spi_cs_start,
  input  logic                  spi_cs_stop,
  output logic [WIDTH-1:0]      spi_value_miso,
  output logic                  reg_req,
  output logic                  reg_we,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  input  logic                  reg_ack
);

  bridge_state_t         r_state, w_state_next;
  logic                  r_req, r_we, r_timeout, r_ovr, r_inv;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_result;
  logic [WIDTH-1:0]      r_miso;
  logic                  w_expire, w_ovr_any, w_inv_any, w_ok;
  logic [ADDR_WIDTH-1:0] w_status, w_invalid_status;
  logic                  w_unused;

  // The slave latches spi_value_miso itself at frame start; a registered
  // output already gives it the old value on a coincident update.
  assign w_unused = spi_cs_start;

  assign reg_req        = r_req;
  assign reg_we         = r_we;
  assign reg_addr       = r_addr;
  assign reg_wdata      = r_wdata;
  assign spi_value_miso = r_miso;

  bus_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .system_clk  (system_clk),
    .system_nrst (system_nrst),
    .i_clear     (r_state == ST_IDLE),
    .i_enable    (r_state == ST_BUSY),
    .o_expire    (w_expire)
  );

  // Frame events landing in the DONE cycle still belong to this response.
  assign w_ovr_any = r_ovr | ((r_state == ST_DONE) & spi_value_valid);
  assign w_inv_any = r_inv | ((r_state == ST_DONE) & spi_cs_stop & ~spi_value_valid);
  assign w_ok      = ~(r_timeout | w_ovr_any | w_inv_any);

  // Status fields for the normal response and the idle invalid-frame word.
  always_comb begin
    w_status                         = '0;
    w_status[STATUS_TIMEOUT]         = r_timeout;
    w_status[STATUS_OVERRUN]         = w_ovr_any;
    w_status[STATUS_INVALID]         = w_inv_any;
    w_status[STATUS_WRITE]           = r_we;
    w_invalid_status                 = '0;
    w_invalid_status[STATUS_INVALID] = 1'b1;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (spi_value_valid) w_state_next = ST_BUSY;
        else                 w_state_next = ST_IDLE;
      end
      ST_BUSY: begin
        if (reg_ack || w_expire) w_state_next = ST_DONE;
        else                     w_state_next = ST_BUSY;
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge system_clk or negedge system_nrst) begin
    if (!system_nrst) r_state <= ST_IDLE;
    else              r_state <= w_state_next;
  end

  // Command latch, bus handshake and response load.
  always_ff @(posedge system_clk or negedge system_nrst) begin
    if (!system_nrst) begin
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_result  <= '0;
      r_timeout <= 1'b0;
      r_miso    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (spi_value_valid) begin
            r_req     <= 1'b1;
            r_we      <= spi_value_mosi[WIDTH-1];
            r_addr    <= spi_value_mosi[WIDTH-2:DATA_WIDTH];
            r_wdata   <= spi_value_mosi[DATA_WIDTH-1:0];
            r_timeout <= 1'b0;
          end else if (spi_cs_stop) begin
            r_miso <= {1'b0, w_invalid_status, {DATA_WIDTH{1'b0}}};
          end
        end
        ST_BUSY: begin
          if (reg_ack) begin
            r_req    <= 1'b0;
            r_result <= r_we ? r_wdata : reg_rdata;
          end else if (w_expire) begin
            r_req     <= 1'b0;
            r_timeout <= 1'b1;
            r_result  <= '0;
          end
        end
        ST_DONE: r_miso <= {w_ok, w_status, r_result};
        default: r_req  <= 1'b0;
      endcase
    end
  end

  // Sticky overrun/invalid flags gathered while a command is in flight.
  always_ff @(posedge system_clk or negedge system_nrst) begin
    if (!system_nrst) begin
      r_ovr <= 1'b0;
      r_inv <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_ovr <= 1'b0;
      r_inv <= 1'b0;
    end else if (r_state == ST_BUSY) begin
      if (spi_value_valid)  r_ovr <= 1'b1;
      else if (spi_cs_stop) r_inv <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_register_bridge.sv
// Randomized self-checking bench for spi_register_bridge with a
// transaction-level response model.
module tb_spi_register_bridge;

  localparam int AW = 7;
  localparam int DW = 24;
  localparam int T  = 4;
  localparam int W  = 1 + AW + DW;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [W-1:0]  mosi = '0;
  logic          valid = 1'b0, cs_start = 1'b0, cs_stop = 1'b0;
  logic [W-1:0]  miso;
  logic          req, we, ack = 1'b0;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata = '0;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] last_exp = '0;

  always #5 clk = ~clk;

  spi_register_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
    .system_clk(clk), .system_nrst(nrst),
    .spi_value_mosi(mosi), .spi_value_valid(valid),
    .spi_cs_start(cs_start), .spi_cs_stop(cs_stop),
    .spi_value_miso(miso),
    .reg_req(req), .reg_we(we), .reg_addr(addr), .reg_wdata(wdata),
    .reg_rdata(rdata), .reg_ack(ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected response word from the command, ack delay and frame events.
  function automatic logic [W-1:0] model(input logic [W-1:0] cmd, input int d,
                                         input logic [DW-1:0] rd, input bit ovr, input bit inv);
    bit wr = cmd[W-1];
    bit to = (d >= T);
    logic [DW-1:0] data = to ? '0 : (wr ? cmd[DW-1:0] : rd);
    logic [AW-1:0] st = '0;
    st[0] = to; st[1] = ovr; st[2] = inv; st[3] = wr;
    return {~(to | ovr | inv), st, data};
  endfunction

  // One command frame; ack d cycles into the request window (d >= T: none).
  task automatic do_txn(input logic [W-1:0] cmd, input int d, input logic [DW-1:0] rd,
                        input bit inj_v, input bit inj_s, input bit with_stop, input string name);
    int  k = 0;
    int  req_cycles = 0;
    bit  stable = 1'b1;
    int  exp_cycles = (d < T) ? d + 1 : T;
    logic [W-1:0] exp;
    mosi = cmd; valid = 1'b1; cs_stop = with_stop;
    tick();
    valid = 1'b0; cs_stop = 1'b0;
    checks++;
    if (req !== 1'b1) begin
      errors++; $display("FAIL %s req_latency: got %b want 1", name, req);
    end
    while (req === 1'b1 && k < 20) begin
      if (we !== cmd[W-1] || addr !== cmd[W-2:DW] || (cmd[W-1] && wdata !== cmd[DW-1:0]))
        stable = 1'b0;
      req_cycles++;
      ack = (k == d); rdata = (k == d) ? rd : DW'($urandom);
      if (k == 0 && inj_v) begin valid = 1'b1; mosi = ~cmd; end
      if (k == 0 && inj_s) cs_stop = 1'b1;
      tick();
      ack = 1'b0; valid = 1'b0; cs_stop = 1'b0;
      k++;
    end
    checks++;
    if (!stable) begin
      errors++; $display("FAIL %s bus_fields: we/addr/wdata not %h during req", name, cmd);
    end
    checks++;
    if (req_cycles != exp_cycles) begin
      errors++; $display("FAIL %s req_cycles: got %0d want %0d", name, req_cycles, exp_cycles);
    end
    tick();
    exp = model(cmd, d, rd, inj_v, inj_s && !inj_v);
    checks++;
    if (miso !== exp) begin
      errors++; $display("FAIL %s miso: got %h want %h", name, miso, exp);
    end
    last_exp = exp;
  endtask

  task automatic test_reset();
    checks++;
    if (req !== 1'b0 || we !== 1'b0 || addr !== '0 || wdata !== '0 || miso !== '0) begin
      errors++; $display("FAIL reset: req=%b we=%b addr=%h wdata=%h miso=%h want all 0",
                         req, we, addr, wdata, miso);
    end
  endtask

  task automatic test_read();
    do_txn(32'h05_000000, 2, 24'hABCDEF, 0, 0, 0, "read");
    checks++;
    if (miso !== 32'h80ABCDEF) begin
      errors++; $display("FAIL read_const: got %h want 80abcdef", miso);
    end
  endtask

  task automatic test_write();
    do_txn(32'h8A_123456, 1, 24'h000000, 0, 0, 0, "write");
    checks++;
    if (miso !== 32'h88123456) begin
      errors++; $display("FAIL write_const: got %h want 88123456", miso);
    end
  endtask

  task automatic test_timeout();
    do_txn(32'h05_000000, 100, 24'h0, 0, 0, 0, "timeout");
    checks++;
    if (miso !== 32'h01000000) begin
      errors++; $display("FAIL timeout_const: got %h want 01000000", miso);
    end
    do_txn(32'h33_000000, T - 1, 24'h5A5A5A, 0, 0, 0, "ack_at_expiry");
  endtask

  task automatic test_overrun();
    do_txn(32'h05_000000, 2, 24'h000001, 1, 0, 0, "overrun");
    checks++;
    if (miso !== 32'h02000001) begin
      errors++; $display("FAIL overrun_const: got %h want 02000001", miso);
    end
    do_txn(32'h11_000000, 1, 24'h777777, 0, 1, 0, "busy_invalid");
  endtask

  task automatic test_invalid_idle();
    int hits = 0;
    cs_stop = 1'b1;
    tick();
    cs_stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (req === 1'b1) hits++;
      tick();
    end
    checks++;
    if (miso !== 32'h04000000 || hits != 0) begin
      errors++; $display("FAIL invalid_idle: miso=%h req_hits=%0d want 04000000/0", miso, hits);
    end
    last_exp = 32'h04000000;
  endtask

  task automatic test_valid_with_stop();
    do_txn(32'h9F_ABC123, 0, 24'h0, 0, 0, 1, "valid_with_stop");
  endtask

  task automatic test_ack_outside_busy();
    ack = 1'b1; rdata = 24'hFFFFFF;
    tick();
    ack = 1'b0;
    tick();
    checks++;
    if (req !== 1'b0 || miso !== last_exp) begin
      errors++; $display("FAIL ack_idle: req=%b miso=%h want 0/%h", req, miso, last_exp);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] cmd = W'($urandom);
      int d = $urandom_range(0, T + 1);
      bit iv = ($urandom_range(0, 4) == 0);
      bit is = ($urandom_range(0, 4) == 0);
      do_txn(cmd, d, DW'($urandom), iv, is, 0, "random");
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      do_txn(W'($urandom), $urandom_range(0, T - 1), DW'($urandom), 0, 0, 0, "back_to_back");
  endtask

  task automatic test_reset_mid();
    mosi = 32'h05_000000; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    nrst = 1'b0;
    #1;
    checks++;
    if (req !== 1'b0 || miso !== '0) begin
      errors++; $display("FAIL reset_mid: req=%b miso=%h want 0/0", req, miso);
    end
    tick();
    nrst = 1'b1;
    tick();
    do_txn(32'h06_000000, 1, 24'h13579B, 0, 0, 0, "after_reset");
  endtask

  initial begin
    repeat (2) tick();
    test_reset();
    nrst = 1'b1;
    tick();
    test_read();
    test_write();
    test_timeout();
    test_overrun();
    test_invalid_idle();
    test_valid_with_stop();
    test_ack_outside_busy();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_register_bridge.md
Name: spi_register_bridge

Overview:
- Command sequencer behind a simple_spi_slave instance: decodes each received SPI word as a register read/write command, executes it on an on-chip req/ack register bus, and loads the result into the slave's transmit word for the next SPI transaction.
- Sits between the SPI slave's value interface and the local register file/peripherals.
- Responses are pipelined: the result of frame N is shifted out during frame N+1.

Parameters:
- ADDR_WIDTH, 7, register address bits; must be >= 4.
- DATA_WIDTH, 24, register data bits.
- TIMEOUT_CYCLES, 255, max cycles reg_req may wait for reg_ack; 0 disables timeout.
- Derived localparam WIDTH = 1+ADDR_WIDTH+DATA_WIDTH (32 by default); must equal the slave's WIDTH.

Ports:
- system_clk  in  1  system clock; all logic on rising edge.
- system_nrst  in  1  asynchronous, active-low reset.
- spi_value_mosi  in  WIDTH  received word from the slave.
- spi_value_valid  in  1  one-cycle pulse: complete frame received.
- spi_cs_start  in  1  one-cycle pulse: frame begins; slave captures spi_value_miso now.
- spi_cs_stop  in  1  one-cycle pulse: frame ends.
- spi_value_miso  out  WIDTH  response word for the next frame.
- reg_req  out  1  bus request, held until ack/timeout.
- reg_we  out  1  1 = write, 0 = read; valid while reg_req.
- reg_addr  out  ADDR_WIDTH  bus address.
- reg_wdata  out  DATA_WIDTH  write data.
- reg_rdata  in  DATA_WIDTH  read data; sampled in the reg_ack cycle.
- reg_ack  in  1  one-cycle completion pulse.

Behaviour:
- Command word: [WIDTH-1] = write flag; [WIDTH-2:DATA_WIDTH] = address; [DATA_WIDTH-1:0] = write data (ignored for reads).
- Response word: [WIDTH-1] = ok; [WIDTH-2:DATA_WIDTH] = status field, where bit0 = timeout, bit1 = overrun, bit2 = invalid frame, bit3 = last command was write, and upper bits are 0; [DATA_WIDTH-1:0] = read data, echoed write data, or 0 on error.
- Reset (async): state IDLE; reg_req, reg_we, reg_addr, reg_wdata, spi_value_miso, sticky flags and timeout counter all 0. Reset mid-access drops reg_req immediately; the pending command is lost.
- FSM:
  - IDLE --spi_value_valid--> BUSY. Latch the command; reg_req=1 from the next cycle (latency 1); timeout counter cleared.
  - IDLE --spi_cs_stop without spi_value_valid--> stays IDLE. spi_value_miso loads {ok=0, status.invalid=1, data=0} on the next edge; no bus access.
  - BUSY --reg_ack--> DONE. Capture reg_rdata (read) or echo wdata (write); reg_req=0 next cycle.
  - BUSY --counter reaches TIMEOUT_CYCLES-1 without ack--> DONE with timeout=1, data=0, reg_req=0 next cycle. An ack in that same cycle wins over the timeout.
  - DONE (1 cycle): spi_value_miso loads the response, ORing in the sticky overrun/invalid flags. ok = no timeout and no sticky flag. Sticky flags clear. Go to IDLE.
- spi_value_valid while BUSY/DONE: command dropped, sticky overrun set. spi_cs_stop without valid while BUSY/DONE: sticky invalid set.
- spi_value_valid and spi_cs_stop in the same cycle form one valid frame, not an invalid one.
- spi_cs_start coincident with a spi_value_miso update: the slave captures the old value; the new value goes out in the following frame.
- reg_ack outside BUSY is ignored.
- reg_addr, reg_we and reg_wdata are stable for the whole reg_req window.
- Counter width = $clog2(TIMEOUT_CYCLES+1); no wrap.

Decomposition:
- Shared header spi_register_bridge_defs.vh holds:
  - command and response field bit positions;
  - status bit indices (STATUS_TIMEOUT=0, STATUS_OVERRUN=1, STATUS_INVALID=2, STATUS_WRITE=3);
  - FSM state encodings (IDLE, BUSY, DONE).
- One natural sub-module: bus_timeout_counter (clear, enable, expire output; TIMEOUT_CYCLES=0 never expires).

Test Plan:
- Read: valid pulse with mosi=0x05_000000 (read, addr 0x05) -> reg_req next cycle with reg_we=0, reg_addr=0x05; ack after 3 cycles with rdata=0xABCDEF -> spi_value_miso=0x80ABCDEF.
- Write: mosi=0x8A_123456 -> reg_we=1, reg_addr=0x0A, reg_wdata=0x123456; ack -> spi_value_miso=0x88123456 (ok, write bit).
- Timeout: TIMEOUT_CYCLES=4, read with no ack -> reg_req high exactly 4 cycles, then spi_value_miso=0x01000000.
- Overrun: second valid pulse while BUSY, then ack with rdata=0x000001 -> spi_value_miso=0x02000001 (ok=0, overrun); the second command never appears on the bus.
- Invalid frame: cs_stop without valid in IDLE -> spi_value_miso=0x04000000, reg_req stays 0.
- Reset mid-access: drop system_nrst while reg_req=1 -> reg_req=0 and spi_value_miso=0 asynchronously; after release a new read completes normally.
